// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Push-button driven LED pattern sequencer. A raw push-button is synchronised,
// debounced and turned into a one-cycle press event. Each press advances a
// 2-bit mode (CHASE_UP -> CHASE_DOWN -> BLINK_ALL -> OFF -> CHASE_UP). A
// prescaler produces a step tick every TICK_DIV cycles, and a 2-bit step
// counter indexes the pattern of the current mode. The lit pattern is
// registered and driven inverted onto the active-low LED pins.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level change
//   TICK_DIV         clock cycles per pattern step
//
// Ports:
//   clk50mhz  in   sole clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   button    in   raw push-button level (0 = pressed)
//   LED1..3   out  active-low LED drives (0 = lit)
//   mode      out  current mode (0 CHASE_UP, 1 CHASE_DOWN, 2 BLINK_ALL, 3 OFF)
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_DIV        = 16_777_216
) (
    input  logic       clk50mhz,
    input  logic       reset_n,
    input  logic       button,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic [1:0] mode
);

    // Counter widths: each counter only has to reach its parameter minus one.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_CHASE_UP   = 2'd0,
        MODE_CHASE_DOWN = 2'd1,
        MODE_BLINK_ALL  = 2'd2,
        MODE_OFF        = 2'd3
    } mode_e;

    // Lit pattern {LED3,LED2,LED1} (1 = lit) for a given mode and step.
    function automatic logic [2:0] lit_pattern(input mode_e m, input logic [1:0] s);
        logic [2:0] p;
        p = 3'b000;
        case (m)
            MODE_CHASE_UP: begin
                case (s)
                    2'd0:    p = 3'b001;
                    2'd1:    p = 3'b010;
                    2'd2:    p = 3'b100;
                    default: p = 3'b000;
                endcase
            end
            MODE_CHASE_DOWN: begin
                case (s)
                    2'd0:    p = 3'b100;
                    2'd1:    p = 3'b010;
                    2'd2:    p = 3'b001;
                    default: p = 3'b000;
                endcase
            end
            MODE_BLINK_ALL: p = s[0] ? 3'b000 : 3'b111;
            default:        p = 3'b000;
        endcase
        return p;
    endfunction

    logic            sync1_q,    sync1_d;
    logic            sync2_q,    sync2_d;
    logic            db_level_q, db_level_d;
    logic [DB_W-1:0] db_cnt_q,   db_cnt_d;
    logic            press_q,    press_d;
    mode_e           mode_q,     mode_d;
    logic [PS_W-1:0] presc_q,    presc_d;
    logic [1:0]      step_q,     step_d;
    logic [2:0]      pattern_q,  pattern_d;
    logic            tick_s;

    // Two-flop synchroniser for the asynchronous button level.
    always_comb begin
        sync1_d = button;
        sync2_d = sync1_q;
    end

    // Debounce: accept the synchronised level only after DEBOUNCE_CYCLES
    // consecutive differing cycles; a press event is the accepted 1->0 edge.
    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = {DB_W{1'b0}};
        press_d    = 1'b0;
        if (sync2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync2_q;
                db_cnt_d   = {DB_W{1'b0}};
                press_d    = ~sync2_q;
            end else begin
                db_cnt_d   = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = {DB_W{1'b0}};
        end
    end

    // Mode advances once per press event, wrapping OFF back to CHASE_UP.
    always_comb begin
        if (press_q) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end else begin
            mode_d = mode_q;
        end
    end

    // Prescaler and step counter; a press restarts both and beats a tick.
    always_comb begin
        tick_s  = (presc_q == PS_LAST);
        presc_d = presc_q;
        step_d  = step_q;
        if (press_q) begin
            presc_d = {PS_W{1'b0}};
            step_d  = 2'd0;
        end else if (tick_s) begin
            presc_d = {PS_W{1'b0}};
            step_d  = step_q + 2'd1;
        end else begin
            presc_d = presc_q + PS_W'(1);
            step_d  = step_q;
        end
    end

    // Pattern follows the registered mode/step, adding one cycle of latency.
    always_comb begin
        pattern_d = lit_pattern(mode_q, step_q);
    end

    // State registers; reset leaves the button "released" and all LEDs dark.
    always_ff @(posedge clk50mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            db_level_q <= 1'b1;
            db_cnt_q   <= {DB_W{1'b0}};
            press_q    <= 1'b0;
            mode_q     <= MODE_CHASE_UP;
            presc_q    <= {PS_W{1'b0}};
            step_q     <= 2'd0;
            pattern_q  <= 3'b000;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            step_q     <= step_d;
            pattern_q  <= pattern_d;
        end
    end

    assign LED1 = ~pattern_q[0];
    assign LED2 = ~pattern_q[1];
    assign LED3 = ~pattern_q[2];
    assign mode = mode_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable clk50mhz cycles (20 ms) required to accept a button level change.
REQ-002 SHALL have parameter TICK_DIV, default 16_777_216, clk50mhz cycles per pattern step (~0.34 s).
REQ-003 SHALL have port clk50mhz  input  1  sole clock, 50 MHz, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset; assertion acts immediately, release is synchronous to clk50mhz.
REQ-005 SHALL have port button  input  1  raw asynchronous push-button level, 0 = pressed, 1 = released.
REQ-006 SHALL have port LED1  output  1  LED 1 drive, active-low (0 = lit).
REQ-007 SHALL have port LED2  output  1  LED 2 drive, active-low.
REQ-008 SHALL have port LED3  output  1  LED 3 drive, active-low.
REQ-009 SHALL have port mode  output  2  current mode: 0 CHASE_UP, 1 CHASE_DOWN, 2 BLINK_ALL, 3 OFF.

Function
REQ-010 SHALL pass button through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce: the debounced level takes the synchronized value only after it has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced value restarts the count at 0.
REQ-012 SHALL generate a one-cycle press event when the debounced level goes 1->0; release (0->1) generates no event.
REQ-013 SHALL advance mode by 1 on each press event, wrapping from 3 (OFF) back to 0 (CHASE_UP).
REQ-014 SHALL run a prescaler counting 0..TICK_DIV-1 that issues a one-cycle tick when at TICK_DIV-1, then wraps to 0.
REQ-015 SHALL hold a 2-bit step counter that increments on each tick and wraps from 3 to 0.
REQ-016 SHALL clear both prescaler and step to 0 on the cycle after a press event, overriding any tick in the same cycle (press wins).
REQ-017 SHALL compute lit pattern {LED3,LED2,LED1} in CHASE_UP as step 0:001, 1:010, 2:100, 3:000.
REQ-018 SHALL compute CHASE_DOWN as step 0:100, 1:010, 2:001, 3:000.
REQ-019 SHALL compute BLINK_ALL as 111 when step[0]=0, 000 when step[0]=1.
REQ-020 SHALL compute OFF as 000 regardless of step; prescaler and step keep running in OFF.
REQ-021 SHALL register the lit pattern; LEDx pins SHALL be the inverse of the registered bit, giving one cycle latency from mode/step change to pins.
REQ-022 SHALL keep mode as a register driven directly onto the mode port (no output latency beyond the register).
REQ-023 SHALL hold the button pressed indefinitely without generating further press events (no auto-repeat).
REQ-024 SHALL ignore button glitches shorter than DEBOUNCE_CYCLES in either direction.

Reset
REQ-025 SHALL, while reset_n=0, force mode=0, step=0, prescaler=0, debounce count=0, synchronizer flops and debounced level=1 (released), pattern register=000 so LED1..LED3=1 (all dark).
REQ-026 SHALL, on the first rising clock edge after reset_n release, load CHASE_UP step 0 into the pattern register, so LED1=0 one cycle after release.
REQ-027 SHALL, on reset asserted mid-press or mid-debounce, discard the pending change; a button still held at release SHALL require a full DEBOUNCE_CYCLES stable-pressed interval plus a fresh 1->0 debounced edge; since debounced level resets to 1, a held button SHALL produce exactly one press event DEBOUNCE_CYCLES+2 cycles after release.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-028 SHALL check reset: reset_n=0 mid-run -> LED1..3=1, mode=0 immediately; release -> LED1=0, LED2=LED3=1 after 1 cycle; LED2=0 after 8 more cycles.
REQ-029 SHALL check chase wrap: no button, 32 cycles after reset -> LED lit sequence 001,010,100,000 each lasting 8 cycles, then 001 again.
REQ-030 SHALL check debounce: button low for 3 cycles then high -> mode stays 0; button low 10 cycles -> mode becomes 1 exactly once, LED3 lit (100) one cycle after step clears.
REQ-031 SHALL check mode wrap: four clean presses -> mode 1,2,3,0; in mode 2 LEDs alternate 111/000 every 8 cycles; in mode 3 all LEDx=1.
REQ-032 SHALL check press/tick collision: debounced press landing on prescaler=7 -> step=0, prescaler=0 next cycle, new mode's step-0 pattern on pins the cycle after.
REQ-033 SHALL check held button: button low 100 cycles -> exactly one mode increment; bounce train (low 2, high 1, repeated) -> no increment.
